// File: rtl/id_scan_pkg.sv
// -----------------------------------------------------------------------------
// id_scan_pkg
// Shared types and constants for the identifier scanner:
//   - char_class_e : classification of one input character
//   - state_e      : scanner FSM states
//   - ASCII_*      : character range bounds used by the classifier
// -----------------------------------------------------------------------------
package id_scan_pkg;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_DIGIT = 2'd1,
    CLS_ALPHA = 2'd2
  } char_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALPHA = 2'd1,
    ST_DIGIT = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_0     = 8'h30;  // '0'
  localparam logic [7:0] ASCII_9     = 8'h39;  // '9'
  localparam logic [7:0] ASCII_UP_A  = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_UP_Z  = 8'h5A;  // 'Z'
  localparam logic [7:0] ASCII_LO_A  = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_LO_Z  = 8'h7A;  // 'z'
  localparam logic [7:0] ASCII_UNDER = 8'h5F;  // '_'

endpackage

// File: rtl/id_scanner_if.sv
// -----------------------------------------------------------------------------
// id_scanner_if
// Character-stream bus between a character source (master) and the
// identifier scanner (slave). Suffixes are from the scanner's point of view.
//   char_i       8      ASCII character
//   char_valid_i 1      character qualifier
//   match_o      1      current token qualifies
//   id_len_o     LEN_W  length of current token so far (saturating)
//   done_o       1      one-cycle pulse: qualifying token terminated
//   done_len_o   LEN_W  length of the terminated token
//   id_count_o   CNT_W  number of completed qualifying tokens (saturating)
// -----------------------------------------------------------------------------
interface id_scanner_if #(
  parameter int LEN_W = 6,
  parameter int CNT_W = 16
);
  logic [7:0]       char_i;
  logic             char_valid_i;
  logic             match_o;
  logic [LEN_W-1:0] id_len_o;
  logic             done_o;
  logic [LEN_W-1:0] done_len_o;
  logic [CNT_W-1:0] id_count_o;

  modport master (
    output char_i, char_valid_i,
    input  match_o, id_len_o, done_o, done_len_o, id_count_o
  );

  modport slave (
    input  char_i, char_valid_i,
    output match_o, id_len_o, done_o, done_len_o, id_count_o
  );
endinterface

// File: rtl/id_char_class.sv
// -----------------------------------------------------------------------------
// id_char_class
// Purely combinational ASCII classifier: DIGIT ('0'-'9'), ALPHA ('a'-'z',
// 'A'-'Z'), OTHER (everything else).
// Build option: UNDERSCORE_EN -- when defined, '_' is classified as ALPHA
// so C-style identifiers are recognised; otherwise '_' is OTHER.
//   char_i   in   8  ASCII character
//   class_o  out  2  character class (char_class_e)
// -----------------------------------------------------------------------------
module id_char_class
  import id_scan_pkg::*;
(
  input  logic [7:0]  char_i,
  output char_class_e class_o
);

  logic is_digit;
  logic is_letter;
  logic is_under;

  assign is_digit  = (char_i >= ASCII_0) && (char_i <= ASCII_9);
  assign is_letter = ((char_i >= ASCII_UP_A) && (char_i <= ASCII_UP_Z)) ||
                     ((char_i >= ASCII_LO_A) && (char_i <= ASCII_LO_Z));

`ifdef UNDERSCORE_EN
  assign is_under = (char_i == ASCII_UNDER);
`else
  assign is_under = 1'b0;
`endif

  always_comb begin
    class_o = CLS_OTHER;
    if (is_digit)
      class_o = CLS_DIGIT;
    else if (is_letter || is_under)
      class_o = CLS_ALPHA;
  end

endmodule

// File: rtl/id_scanner.sv
// -----------------------------------------------------------------------------
// id_scanner
// Streaming identifier recogniser. A token is a run of >= MIN_ALPHA letters
// followed by >= MIN_DIGIT digits. Outputs are registered and reflect the
// state after the last valid character (one-cycle latency).
// Build option: UNDERSCORE_EN (see id_char_class) treats '_' as a letter.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset, clears all state and outputs
//   bus    slave modport of id_scanner_if (char/valid in, match, id_len,
//          done, done_len, id_count out)
// Parameters: MIN_ALPHA, MIN_DIGIT (>=1), LEN_W (length counter width,
// saturating), CNT_W (token counter width, saturating). LEN_W/CNT_W must
// match the connected interface instance.
// -----------------------------------------------------------------------------
module id_scanner
  import id_scan_pkg::*;
#(
  parameter int MIN_ALPHA = 1,
  parameter int MIN_DIGIT = 1,
  parameter int LEN_W     = 6,
  parameter int CNT_W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  id_scanner_if.slave  bus
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  char_class_e      cls;
  state_e           state_q, state_d;
  logic [LEN_W-1:0] alpha_run_q, alpha_run_d;
  logic [LEN_W-1:0] digit_run_q, digit_run_d;
  logic             match_q;
  logic [LEN_W-1:0] id_len_q;
  logic             done_q;
  logic [LEN_W-1:0] done_len_q;
  logic [CNT_W-1:0] id_count_q;

  logic             alpha_ok;
  logic             match_d;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] id_len_d;
  logic             terminate;

  id_char_class u_class (
    .char_i  (bus.char_i),
    .class_o (cls)
  );

  assign alpha_ok = 32'(alpha_run_q) >= MIN_ALPHA;

  // Next run lengths and state for a valid character.
  always_comb begin
    state_d     = state_q;
    alpha_run_d = alpha_run_q;
    digit_run_d = digit_run_q;
    if (bus.char_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (cls == CLS_ALPHA) begin
            state_d     = ST_ALPHA;
            alpha_run_d = LEN_ONE;
          end
        end
        ST_ALPHA: begin
          if (cls == CLS_ALPHA) begin
            alpha_run_d = (&alpha_run_q) ? alpha_run_q : alpha_run_q + LEN_ONE;
          end else if (cls == CLS_DIGIT && alpha_ok) begin
            state_d     = ST_DIGIT;
            digit_run_d = LEN_ONE;
          end else begin
            state_d     = ST_IDLE;
            alpha_run_d = '0;
            digit_run_d = '0;
          end
        end
        ST_DIGIT: begin
          if (cls == CLS_DIGIT) begin
            digit_run_d = (&digit_run_q) ? digit_run_q : digit_run_q + LEN_ONE;
          end else if (cls == CLS_ALPHA) begin
            // A letter right after a digit run starts a fresh token.
            state_d     = ST_ALPHA;
            alpha_run_d = LEN_ONE;
            digit_run_d = '0;
          end else begin
            state_d     = ST_IDLE;
            alpha_run_d = '0;
            digit_run_d = '0;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          alpha_run_d = '0;
          digit_run_d = '0;
        end
      endcase
    end
  end

  assign match_d  = (state_d == ST_DIGIT) && (32'(digit_run_d) >= MIN_DIGIT);
  assign len_sum  = {1'b0, alpha_run_d} + {1'b0, digit_run_d};
  assign id_len_d = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
  // A qualifying token ends on any non-digit; the registered match is the
  // qualification status before this character.
  assign terminate = bus.char_valid_i && match_q && (cls != CLS_DIGIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      alpha_run_q <= '0;
      digit_run_q <= '0;
      match_q     <= 1'b0;
      id_len_q    <= '0;
      done_q      <= 1'b0;
      done_len_q  <= '0;
      id_count_q  <= '0;
    end else if (bus.char_valid_i) begin
      state_q     <= state_d;
      alpha_run_q <= alpha_run_d;
      digit_run_q <= digit_run_d;
      match_q     <= match_d;
      id_len_q    <= id_len_d;
      done_q      <= terminate;
      if (terminate) begin
        done_len_q <= id_len_q;
        if (!(&id_count_q))
          id_count_q <= id_count_q + CNT_W'(1);
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign bus.match_o    = match_q;
  assign bus.id_len_o   = id_len_q;
  assign bus.done_o     = done_q;
  assign bus.done_len_o = done_len_q;
  assign bus.id_count_o = id_count_q;

endmodule

// File: tb/tb_id_scanner.sv
// -----------------------------------------------------------------------------
// tb_id_scanner
// Three scanner instances share one character stream:
//   dut0 : defaults
//   dut1 : MIN_ALPHA=2, MIN_DIGIT=2
//   dut2 : LEN_W=3
// The driver pushes the hand-computed expected outputs of the selected
// instance into a queue on every driven cycle; a monitor pops and compares
// two time units after each rising edge.
// -----------------------------------------------------------------------------
module tb_id_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ch  = 8'h00;
  logic       vld = 1'b0;

  always #5 clk = ~clk;

  id_scanner_if #(.LEN_W(6), .CNT_W(16)) if0 ();
  id_scanner_if #(.LEN_W(6), .CNT_W(16)) if1 ();
  id_scanner_if #(.LEN_W(3), .CNT_W(16)) if2 ();

  assign if0.char_i = ch;  assign if0.char_valid_i = vld;
  assign if1.char_i = ch;  assign if1.char_valid_i = vld;
  assign if2.char_i = ch;  assign if2.char_valid_i = vld;

  id_scanner #(.MIN_ALPHA(1), .MIN_DIGIT(1), .LEN_W(6), .CNT_W(16)) dut0 (
    .clk(clk), .reset(rst), .bus(if0.slave));
  id_scanner #(.MIN_ALPHA(2), .MIN_DIGIT(2), .LEN_W(6), .CNT_W(16)) dut1 (
    .clk(clk), .reset(rst), .bus(if1.slave));
  id_scanner #(.MIN_ALPHA(1), .MIN_DIGIT(1), .LEN_W(3), .CNT_W(16)) dut2 (
    .clk(clk), .reset(rst), .bus(if2.slave));

  typedef struct {
    int    dut;
    logic  m;
    int    len;
    logic  d;
    int    dlen;
    int    cnt;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  string cur_tag = "init";

  // Monitor: compare the selected instance against the oldest expectation.
  initial begin : monitor
    exp_t e;
    logic a_m, a_d;
    int   a_len, a_dlen, a_cnt;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.dut)
          1: begin
            a_m = if1.match_o; a_len = int'(if1.id_len_o); a_d = if1.done_o;
            a_dlen = int'(if1.done_len_o); a_cnt = int'(if1.id_count_o);
          end
          2: begin
            a_m = if2.match_o; a_len = int'(if2.id_len_o); a_d = if2.done_o;
            a_dlen = int'(if2.done_len_o); a_cnt = int'(if2.id_count_o);
          end
          default: begin
            a_m = if0.match_o; a_len = int'(if0.id_len_o); a_d = if0.done_o;
            a_dlen = int'(if0.done_len_o); a_cnt = int'(if0.id_count_o);
          end
        endcase
        checks++;
        if (a_m !== e.m || a_len != e.len || a_d !== e.d ||
            a_dlen != e.dlen || a_cnt != e.cnt) begin
          errors++;
          $display("FAIL %s dut%0d: got m=%0b len=%0d done=%0b dlen=%0d cnt=%0d, required m=%0b len=%0d done=%0b dlen=%0d cnt=%0d",
                   e.tag, e.dut, a_m, a_len, a_d, a_dlen, a_cnt,
                   e.m, e.len, e.d, e.dlen, e.cnt);
        end else begin
          $display("ok   %s dut%0d: m=%0b len=%0d done=%0b dlen=%0d cnt=%0d",
                   e.tag, e.dut, a_m, a_len, a_d, a_dlen, a_cnt);
        end
      end
    end
  end

  task automatic push(input int dut, input logic m, input int len, input logic d,
                      input int dlen, input int cnt, input string tag);
    exp_t e;
    e.dut = dut; e.m = m; e.len = len; e.d = d; e.dlen = dlen; e.cnt = cnt;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Drive one cycle and queue the expected post-edge outputs.
  task automatic step(input int dut, input logic [7:0] c, input logic v,
                      input logic m, input int len, input logic d,
                      input int dlen, input int cnt);
    string t;
    @(negedge clk);
    rst = 1'b0;
    ch  = c;
    vld = v;
    t = $sformatf("%s '%s' v=%0b", cur_tag, string'(c), v);
    push(dut, m, len, d, dlen, cnt, t);
  endtask

  // Reset held across one rising edge; everything reads zero.
  task automatic do_reset(input int dut);
    @(negedge clk);
    rst = 1'b1;
    vld = 1'b0;
    push(dut, 1'b0, 0, 1'b0, 0, 0, {cur_tag, " reset"});
  endtask

  initial begin : driver
    // ---- defaults, "ab12 "
    cur_tag = "ab12";
    do_reset(0);
    step(0, "a", 1, 0, 1, 0, 0, 0);
    step(0, "b", 1, 0, 2, 0, 0, 0);
    step(0, "1", 1, 1, 3, 0, 0, 0);
    step(0, "2", 1, 1, 4, 0, 0, 0);
    step(0, " ", 1, 0, 0, 1, 4, 1);
    step(0, "x", 0, 0, 0, 0, 4, 1);   // done drops, done_len held

    // ---- "1a2b3;" : termination by a letter starts a new token
    cur_tag = "1a2b3";
    do_reset(0);
    step(0, "1", 1, 0, 0, 0, 0, 0);
    step(0, "a", 1, 0, 1, 0, 0, 0);
    step(0, "2", 1, 1, 2, 0, 0, 0);
    step(0, "b", 1, 0, 1, 1, 2, 1);
    step(0, "3", 1, 1, 2, 0, 2, 1);
    step(0, ";", 1, 0, 0, 1, 2, 2);

    // ---- valid gap
    cur_tag = "gap";
    do_reset(0);
    step(0, "a", 1, 0, 1, 0, 0, 0);
    step(0, "9", 0, 0, 1, 0, 0, 0);
    step(0, "9", 0, 0, 1, 0, 0, 0);
    step(0, "9", 0, 0, 1, 0, 0, 0);
    step(0, "7", 1, 1, 2, 0, 0, 0);

    // ---- upper case and class boundaries: "@[`{Q0/"
    cur_tag = "bounds";
    do_reset(0);
    step(0, "@", 1, 0, 0, 0, 0, 0);
    step(0, "[", 1, 0, 0, 0, 0, 0);
    step(0, 8'h60, 1, 0, 0, 0, 0, 0);
    step(0, "{", 1, 0, 0, 0, 0, 0);
    step(0, "Q", 1, 0, 1, 0, 0, 0);
    step(0, "0", 1, 1, 2, 0, 0, 0);
    step(0, "/", 1, 0, 0, 1, 2, 1);

    // ---- MIN_ALPHA=2, MIN_DIGIT=2: "a12 ab1 ab12 "
    cur_tag = "min2";
    do_reset(1);
    step(1, "a", 1, 0, 1, 0, 0, 0);
    step(1, "1", 1, 0, 0, 0, 0, 0);
    step(1, "2", 1, 0, 0, 0, 0, 0);
    step(1, " ", 1, 0, 0, 0, 0, 0);
    step(1, "a", 1, 0, 1, 0, 0, 0);
    step(1, "b", 1, 0, 2, 0, 0, 0);
    step(1, "1", 1, 0, 3, 0, 0, 0);
    step(1, " ", 1, 0, 0, 0, 0, 0);
    step(1, "a", 1, 0, 1, 0, 0, 0);
    step(1, "b", 1, 0, 2, 0, 0, 0);
    step(1, "1", 1, 0, 3, 0, 0, 0);
    step(1, "2", 1, 1, 4, 0, 0, 0);
    step(1, " ", 1, 0, 0, 1, 4, 1);

    // ---- LEN_W=3 saturation: "abcdefghij1 "
    cur_tag = "sat";
    do_reset(2);
    step(2, "a", 1, 0, 1, 0, 0, 0);
    step(2, "b", 1, 0, 2, 0, 0, 0);
    step(2, "c", 1, 0, 3, 0, 0, 0);
    step(2, "d", 1, 0, 4, 0, 0, 0);
    step(2, "e", 1, 0, 5, 0, 0, 0);
    step(2, "f", 1, 0, 6, 0, 0, 0);
    step(2, "g", 1, 0, 7, 0, 0, 0);
    step(2, "h", 1, 0, 7, 0, 0, 0);
    step(2, "i", 1, 0, 7, 0, 0, 0);
    step(2, "j", 1, 0, 7, 0, 0, 0);
    step(2, "1", 1, 1, 7, 0, 0, 0);
    step(2, " ", 1, 0, 0, 1, 7, 1);

    // ---- reset mid-token: "ab1", reset, "2"
    cur_tag = "midrst";
    do_reset(0);
    step(0, "a", 1, 0, 1, 0, 0, 0);
    step(0, "b", 1, 0, 2, 0, 0, 0);
    step(0, "1", 1, 1, 3, 0, 0, 0);
    do_reset(0);
    step(0, "2", 1, 0, 0, 0, 0, 0);

    // ---- underscore: "_x9 "
    cur_tag = "under";
    do_reset(0);
`ifdef UNDERSCORE_EN
    step(0, "_", 1, 0, 1, 0, 0, 0);
    step(0, "x", 1, 0, 2, 0, 0, 0);
    step(0, "9", 1, 1, 3, 0, 0, 0);
    step(0, " ", 1, 0, 0, 1, 3, 1);
`else
    step(0, "_", 1, 0, 0, 0, 0, 0);
    step(0, "x", 1, 0, 1, 0, 0, 0);
    step(0, "9", 1, 1, 2, 0, 0, 0);
    step(0, " ", 1, 0, 0, 1, 2, 1);
`endif

    // Drain the scoreboard within a bounded number of cycles.
    @(negedge clk);
    vld = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_scanner.md
Name: id_scanner

Overview:
- Streaming identifier recogniser for an 8-bit character stream.
- A token is a run of at least MIN_ALPHA letters followed by at least MIN_DIGIT digits; the block flags the token while it is being received.
- Extends the single-bit letter/digit detector with:
  - a valid qualifier;
  - configurable minimum run lengths;
  - upper-case letter support;
  - token length reporting;
  - an end-of-token pulse and a running token count.
- Sits after the character source, ahead of the tokenizer/statistics logic.

Parameters:
- MIN_ALPHA, 1, minimum letters before the digit run (≥1)
- MIN_DIGIT, 1, minimum digits for a match (≥1)
- LEN_W, 6, width of length counters; saturate at 2^LEN_W-1
- CNT_W, 16, width of token counter; saturates at all-ones

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state and outputs
- char  in  8  ASCII character
- char_valid  in  1  char sampled only when 1
- match  out  1  current token qualifies (registered)
- id_len  out  LEN_W  length of current token so far, saturating
- done  out  1  one-cycle pulse: qualifying token just terminated
- done_len  out  LEN_W  length of terminated token; valid while done=1, held otherwise
- id_count  out  CNT_W  number of completed qualifying tokens, saturating

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - alpha_run = 0, digit_run = 0.
- Character classes:
  - DIGIT: '0'-'9'
  - ALPHA: 'a'-'z', 'A'-'Z'
  - OTHER: everything else
- Timing and valid qualification:
  - All updates happen on the clk edge where char_valid=1.
  - Outputs reflect state after that character, i.e. 1-cycle latency.
  - char_valid=0: state, match, id_len and id_count hold; done forced 0.
- States and transitions:
  - IDLE
    - ALPHA -> ALPHA, alpha_run=1
    - DIGIT or OTHER -> stay IDLE
  - ALPHA
    - ALPHA -> stay, alpha_run+1 (saturating)
    - DIGIT with alpha_run ≥ MIN_ALPHA -> DIGIT, digit_run=1
    - DIGIT with alpha_run < MIN_ALPHA -> IDLE
    - OTHER -> IDLE
  - DIGIT
    - DIGIT -> stay, digit_run+1 (saturating)
    - ALPHA -> ALPHA, alpha_run=1, digit_run=0 (new token starts)
    - OTHER -> IDLE
- Outputs:
  - match = (state==DIGIT && digit_run ≥ MIN_DIGIT).
  - id_len = alpha_run + digit_run, saturating add at LEN_W. It is 0 in IDLE and restarts at 1 when a new ALPHA run begins.
- Termination:
  - Applies when match=1 before the character and the character is ALPHA or OTHER.
  - done=1 for one cycle.
  - done_len = id_len before the character.
  - id_count+1, saturating.
  - A token ending through a DIGIT that fails the minimum (not qualifying) produces no done.
- Simultaneous events:
  - On termination by ALPHA, done=1 and the new token's id_len=1 in the same cycle.
- Reset mid-token:
  - Clears everything immediately.
  - A digit following reset does not match, because state is IDLE.

Optional Feature:
- Macro UNDERSCORE_EN.
- Defined: '_' is classified as ALPHA (C-style identifiers).
- Undefined: '_' is OTHER.
- No other difference.

Decomposition:
- Package id_scan_pkg:
  - char class enum {CLS_OTHER, CLS_DIGIT, CLS_ALPHA};
  - state enum {ST_IDLE, ST_ALPHA, ST_DIGIT};
  - ASCII bound constants.
- Sub-module id_char_class:
  - purely combinational char -> class;
  - owns the UNDERSCORE_EN ifdef.

Test Plan:
- Defaults, "ab12 " all valid:
  - match 0,0,1,1,0;
  - id_len 1,2,3,4,0;
  - done on ' ' with done_len=4;
  - id_count=1.
- "1a2b3;":
  - match after '2';
  - 'b' -> done, done_len=2, id_len=1;
  - match after '3';
  - ';' -> done, done_len=2;
  - id_count=2.
- 'a' valid, 3 cycles char_valid=0 with char='9', then '7' valid:
  - outputs held during the gap (id_len=1, match=0, done=0);
  - match=1, id_len=2 after '7'.
- MIN_ALPHA=2, MIN_DIGIT=2, "a12 ab1 ab12 ":
  - match only after the final '2' of "ab12";
  - a single done with done_len=4;
  - id_count=1.
- LEN_W=3, "abcdefghij1 ":
  - id_len saturates at 7;
  - done_len=7.
- "ab1" then reset pulse, then "2":
  - all outputs 0 during and after reset;
  - no match after "2".
- "_x9 ":
  - with UNDERSCORE_EN: done_len=3;
  - without: done_len=2.
